// File: rtl/sipo_pkg.sv
// sipo_pkg: shared state encoding and counter sizing for the SIPO frame receiver (PARITY_CHECK_EN adds the PARITY state).
package sipo_pkg;
`ifdef PARITY_CHECK_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_e;
`else
  typedef enum logic {IDLE, SHIFT} state_e;
`endif
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction
endpackage

// File: rtl/sipo_out_buf.sv
// sipo_out_buf: single-entry valid/ready holding register for assembled words and their parity flag.
module sipo_out_buf #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             perr_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             perr_o,
  output logic             full_o,
  output logic             drain_o
);
  logic             valid_q;
  logic [WIDTH-1:0] data_q;
  logic             perr_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      perr_q  <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      perr_q  <= perr_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end
  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign perr_o  = perr_q;
  assign full_o  = valid_q;
  assign drain_o = valid_q && ready_i;
endmodule

// File: rtl/sipo_frame_receiver.sv
// sipo_frame_receiver: MSB-first serial-to-parallel frame receiver with valid/ready output buffer.
// Define PARITY_CHECK_EN to expect a trailing even-parity bit per frame and flag mismatches on m_perr.
module sipo_frame_receiver
  import sipo_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_in,
  input  logic             s_valid,
  input  logic             s_start,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_perr,
  output logic             overrun,
  output logic             resync
);
  localparam int CW = cnt_w(WIDTH);
`ifdef PARITY_CHECK_EN
  localparam int SW = WIDTH;
`else
  localparam int SW = WIDTH - 1;
`endif
  state_e           state_q;
  logic [SW-1:0]    shreg_q;
  logic [CW-1:0]    cnt_q;
  logic             resync_q, overrun_q;
  logic             last_d, done_d, perr_d, load_d, full, drain;
  logic [WIDTH-1:0] word_d;
`ifdef PARITY_CHECK_EN
  logic             par_q;
`endif
  assign last_d = state_q == SHIFT && cnt_q == CW'(WIDTH - 1);
`ifdef PARITY_CHECK_EN
  assign done_d = s_valid && !s_start && state_q == PARITY;
  assign word_d = shreg_q;
  assign perr_d = par_q ^ s_in;
`else
  // Without parity the final data bit is still on s_in when the word completes.
  assign done_d = s_valid && !s_start && last_d;
  assign word_d = {shreg_q, s_in};
  assign perr_d = 1'b0;
`endif
  assign load_d = done_d && (!full || drain);
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      cnt_q     <= '0;
      resync_q  <= 1'b0;
      overrun_q <= 1'b0;
`ifdef PARITY_CHECK_EN
      par_q     <= 1'b0;
`endif
    end else begin
      resync_q  <= s_valid && s_start && state_q != IDLE;
      overrun_q <= overrun_q || (done_d && full && !drain);
      if (s_valid) begin
        if (s_start) begin
          state_q <= SHIFT;
          cnt_q   <= CW'(1);
          shreg_q <= SW'(s_in);
`ifdef PARITY_CHECK_EN
          par_q   <= s_in;
`endif
        end else if (state_q == SHIFT) begin
          shreg_q <= SW'({shreg_q, s_in});
`ifdef PARITY_CHECK_EN
          par_q   <= par_q ^ s_in;
          cnt_q   <= cnt_q + CW'(1);
          state_q <= last_d ? PARITY : SHIFT;
        end else if (state_q == PARITY) begin
          cnt_q   <= '0;
          state_q <= IDLE;
`else
          cnt_q   <= last_d ? '0 : cnt_q + CW'(1);
          state_q <= last_d ? IDLE : SHIFT;
`endif
        end
      end
    end
  end
  sipo_out_buf #(.WIDTH(WIDTH)) u_buf (
    .clk     (clk),
    .reset   (reset),
    .load_i  (load_d),
    .data_i  (word_d),
    .perr_i  (perr_d),
    .ready_i (m_ready),
    .valid_o (m_valid),
    .data_o  (m_data),
    .perr_o  (m_perr),
    .full_o  (full),
    .drain_o (drain)
  );
  assign resync  = resync_q;
  assign overrun = overrun_q;
endmodule

// File: tb/tb_sipo_frame_receiver.sv
// tb_sipo_frame_receiver: directed checks of framing, gaps, overrun, resync, reset and optional parity (PARITY_CHECK_EN).
module tb_sipo_frame_receiver;
  logic       clk = 1'b0;
  logic       reset, s_in, s_valid, s_start, m_ready;
  logic [3:0] m_data;
  logic       m_valid, m_perr, overrun, resync;
  logic       pre_v, first_resync;
  int         n_cmp = 0;
  int         n_err = 0;
  always #5 clk = ~clk;
  sipo_frame_receiver #(.WIDTH(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .s_in    (s_in),
    .s_valid (s_valid),
    .s_start (s_start),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_perr  (m_perr),
    .overrun (overrun),
    .resync  (resync)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic send_bit(input logic st, input logic b);
    s_valid = 1'b1;
    s_start = st;
    s_in    = b;
    @(negedge clk);
    s_valid = 1'b0;
    s_start = 1'b0;
    s_in    = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  // pre_v samples m_valid just before the frame's final bit, first_resync right after its start bit.
  task automatic send_frame(input logic [3:0] d, input logic p, input int gap);
    for (int i = 0; i < 4; i++) begin
`ifndef PARITY_CHECK_EN
      if (i == 3) pre_v = m_valid;
`endif
      send_bit(i == 0, d[3-i]);
      if (i == 0) first_resync = resync;
      if (i == 1) idle(gap);
    end
`ifdef PARITY_CHECK_EN
    pre_v = m_valid;
    send_bit(1'b0, p);
`else
    if (p) idle(0);
`endif
  endtask
  initial begin
    reset = 1'b1; s_in = 1'b0; s_valid = 1'b0; s_start = 1'b0; m_ready = 1'b1;
    idle(3);
    chk("rst_valid", 32'(m_valid), 0);
    chk("rst_data", 32'(m_data), 0);
    chk("rst_perr", 32'(m_perr), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_resync", 32'(resync), 0);
    reset = 1'b0;
    idle(1);
    send_frame(4'hB, 1'b1, 0);
    chk("f1_pre_valid", 32'(pre_v), 0);
    chk("f1_valid", 32'(m_valid), 1);
    chk("f1_data", 32'(m_data), 32'hB);
    chk("f1_perr", 32'(m_perr), 0);
    chk("f1_resync", 32'(first_resync), 0);
    idle(1);
    chk("f1_drained", 32'(m_valid), 0);
    send_frame(4'hB, 1'b1, 2);
    chk("gap_pre_valid", 32'(pre_v), 0);
    chk("gap_valid", 32'(m_valid), 1);
    chk("gap_data", 32'(m_data), 32'hB);
    idle(1);
    send_frame(4'hA, 1'b0, 0);
    chk("b2b_a_data", 32'(m_data), 32'hA);
    send_frame(4'h5, 1'b0, 0);
    chk("b2b_5_valid", 32'(m_valid), 1);
    chk("b2b_5_data", 32'(m_data), 32'h5);
    chk("b2b_overrun", 32'(overrun), 0);
    idle(1);
    m_ready = 1'b0;
    send_frame(4'hA, 1'b0, 0);
    chk("ovr_a_valid", 32'(m_valid), 1);
    chk("ovr_a_data", 32'(m_data), 32'hA);
    chk("ovr_pre", 32'(overrun), 0);
    send_frame(4'h5, 1'b0, 0);
    chk("ovr_hold_data", 32'(m_data), 32'hA);
    chk("ovr_set", 32'(overrun), 1);
    idle(3);
    chk("ovr_sticky", 32'(overrun), 1);
    chk("ovr_hold_valid", 32'(m_valid), 1);
    m_ready = 1'b1;
    idle(1);
    chk("ovr_release", 32'(m_valid), 0);
    chk("ovr_sticky2", 32'(overrun), 1);
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_frame(4'h6, 1'b0, 0);
    chk("rs_pulse", 32'(first_resync), 1);
    chk("rs_single", 32'(resync), 0);
    chk("rs_valid", 32'(m_valid), 1);
    chk("rs_data", 32'(m_data), 32'h6);
    idle(1);
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b1);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    chk("mrst_valid", 32'(m_valid), 0);
    chk("mrst_data", 32'(m_data), 0);
    chk("mrst_overrun", 32'(overrun), 0);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b0);
    chk("mrst_ignored", 32'(m_valid), 0);
    send_frame(4'h9, 1'b0, 0);
    chk("mrst_valid9", 32'(m_valid), 1);
    chk("mrst_data9", 32'(m_data), 32'h9);
`ifdef PARITY_CHECK_EN
    idle(1);
    send_frame(4'hB, 1'b0, 0);
    chk("par_bad_perr", 32'(m_perr), 1);
    chk("par_bad_data", 32'(m_data), 32'hB);
    chk("par_bad_valid", 32'(m_valid), 1);
    idle(1);
    send_frame(4'hB, 1'b1, 0);
    chk("par_ok_perr", 32'(m_perr), 0);
`else
    chk("noparity_perr", 32'(m_perr), 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
